// File: rtl/lock_entry_ctrl.sv
// lock_entry_ctrl
//   Keypad-side sequencer for the combination-lock checker. Buffers digit
//   keys, handles clear/enter, discards stale partial entries, and on a
//   complete entry drives the checker with one enter pulse followed by one
//   BCD digit per cycle. It then waits for the grant/deny/lock verdict and
//   reports it upstream.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   synchronous active-low reset
//   key_valid   in   one-cycle strobe qualifying key_code
//   key_code    in   [3:0] 0-9 digit, A clear, B enter, C-F ignored
//   chk_grant   in   checker grant
//   chk_deny    in   checker deny
//   chk_lock    in   checker lock
//   chk_enter   out  checker enter_button, one-cycle pulse
//   chk_digit   out  [3:0] checker ip_pass
//   busy        out  high in ISSUE, WAIT_RES, LOCKED
//   digit_cnt   out  [2:0] digits buffered, 0-4
//   entry_ok    out  one-cycle pulse on grant
//   entry_fail  out  one-cycle pulse on deny
//   entry_err   out  one-cycle pulse on protocol/timeout error
//   locked_out  out  high while LOCKED
module lock_entry_ctrl #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned KEY_TIMEOUT    = 50000000,
  parameter int unsigned RESULT_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       chk_grant,
  input  logic       chk_deny,
  input  logic       chk_lock,
  output logic       chk_enter,
  output logic [3:0] chk_digit,
  output logic       busy,
  output logic [2:0] digit_cnt,
  output logic       entry_ok,
  output logic       entry_fail,
  output logic       entry_err,
  output logic       locked_out
);

  localparam int unsigned KT_W = (KEY_TIMEOUT > 2) ? $clog2(KEY_TIMEOUT) : 1;
  localparam int unsigned RT_W = (RESULT_TIMEOUT > 2) ? $clog2(RESULT_TIMEOUT) : 1;
  localparam logic [KT_W-1:0] KT_LAST = KT_W'(KEY_TIMEOUT - 1);
  localparam logic [RT_W-1:0] RT_LAST = RT_W'(RESULT_TIMEOUT - 1);
  localparam logic [2:0]      CNT_FULL = 3'(DIGITS);

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RES = 2'd2,
    LOCKED   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [DIGITS-1:0][3:0] buf_q, buf_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [KT_W-1:0]        ktmr_q, ktmr_d;
  logic [RT_W-1:0]        rtmr_q, rtmr_d;
  logic [1:0]             idx_q, idx_d;
  logic                   deny_seen_q, deny_seen_d;

  logic       enter_q, enter_d;
  logic [3:0] digit_q, digit_d;
  logic       busy_q, ok_q, ok_d, fail_q, fail_d, err_q, err_d, locked_q;

  logic key_digit, key_clear, key_enter;

  assign key_digit = key_valid && (key_code <= 4'd9);
  assign key_clear = key_valid && (key_code == 4'hA);
  assign key_enter = key_valid && (key_code == 4'hB);

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    ktmr_d      = ktmr_q;
    rtmr_d      = rtmr_q;
    idx_d       = idx_q;
    deny_seen_d = deny_seen_q;
    enter_d     = 1'b0;
    digit_d     = '0;
    ok_d        = 1'b0;
    fail_d      = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      COLLECT: begin
        // Timeout is checked before any key so a coincident key is lost.
        if ((cnt_q != 3'd0) && (ktmr_q == KT_LAST)) begin
          buf_d  = '0;
          cnt_d  = '0;
          ktmr_d = '0;
          err_d  = 1'b1;
        end else if (key_digit) begin
          ktmr_d = '0;
          if (cnt_q < CNT_FULL) begin
            buf_d[cnt_q[1:0]] = key_code;
            cnt_d             = cnt_q + 3'd1;
          end else begin
            err_d = 1'b1;
          end
        end else if (key_clear) begin
          buf_d  = '0;
          cnt_d  = '0;
          ktmr_d = '0;
        end else if (key_enter) begin
          ktmr_d = '0;
          if (cnt_q == CNT_FULL) begin
            state_d = ISSUE;
            enter_d = 1'b1;
            idx_d   = '0;
          end else begin
            buf_d = '0;
            cnt_d = '0;
            err_d = 1'b1;
          end
        end else if (cnt_q != 3'd0) begin
          // Ignored codes C-F fall through here and keep the timer running.
          ktmr_d = ktmr_q + KT_W'(1);
        end
      end

      ISSUE: begin
        digit_d = buf_q[idx_q];
        idx_d   = idx_q + 2'd1;
        if (idx_q == 2'(DIGITS - 1)) begin
          state_d     = WAIT_RES;
          rtmr_d      = '0;
          deny_seen_d = 1'b0;
        end
      end

      WAIT_RES: begin
        if (deny_seen_q) begin
          // Extra cycle after a deny exists only to sample the lock verdict.
          deny_seen_d = 1'b0;
          state_d     = chk_lock ? LOCKED : COLLECT;
        end else if (chk_deny) begin
          fail_d      = 1'b1;
          buf_d       = '0;
          cnt_d       = '0;
          deny_seen_d = 1'b1;
        end else if (chk_grant) begin
          ok_d    = 1'b1;
          buf_d   = '0;
          cnt_d   = '0;
          state_d = COLLECT;
        end else if (chk_lock) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = LOCKED;
        end else if (rtmr_q == RT_LAST) begin
          err_d   = 1'b1;
          buf_d   = '0;
          cnt_d   = '0;
          state_d = COLLECT;
        end else begin
          rtmr_d = rtmr_q + RT_W'(1);
        end
      end

      LOCKED: begin
        if (!chk_lock) begin
          state_d = COLLECT;
        end
      end

      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      buf_q       <= '0;
      cnt_q       <= '0;
      ktmr_q      <= '0;
      rtmr_q      <= '0;
      idx_q       <= '0;
      deny_seen_q <= 1'b0;
      enter_q     <= 1'b0;
      digit_q     <= '0;
      busy_q      <= 1'b0;
      ok_q        <= 1'b0;
      fail_q      <= 1'b0;
      err_q       <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      ktmr_q      <= ktmr_d;
      rtmr_q      <= rtmr_d;
      idx_q       <= idx_d;
      deny_seen_q <= deny_seen_d;
      enter_q     <= enter_d;
      digit_q     <= digit_d;
      busy_q      <= (state_d != COLLECT);
      ok_q        <= ok_d;
      fail_q      <= fail_d;
      err_q       <= err_d;
      locked_q    <= (state_d == LOCKED);
    end
  end

  assign chk_enter  = enter_q;
  assign chk_digit  = digit_q;
  assign busy       = busy_q;
  assign digit_cnt  = cnt_q;
  assign entry_ok   = ok_q;
  assign entry_fail = fail_q;
  assign entry_err  = err_q;
  assign locked_out = locked_q;

endmodule

// File: tb/tb_lock_entry_ctrl.sv
module tb_lock_entry_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       chk_grant, chk_deny, chk_lock;
  logic       chk_enter;
  logic [3:0] chk_digit;
  logic       busy;
  logic [2:0] digit_cnt;
  logic       entry_ok, entry_fail, entry_err, locked_out;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_q[$];

  lock_entry_ctrl #(
    .DIGITS        (4),
    .KEY_TIMEOUT   (8),
    .RESULT_TIMEOUT(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .chk_grant (chk_grant),
    .chk_deny  (chk_deny),
    .chk_lock  (chk_lock),
    .chk_enter (chk_enter),
    .chk_digit (chk_digit),
    .busy      (busy),
    .digit_cnt (digit_cnt),
    .entry_ok  (entry_ok),
    .entry_fail(entry_fail),
    .entry_err (entry_err),
    .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    tick();
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic press_digits(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d);
    logic [3:0] ds[4];
    ds = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      press(ds[i]);
      exp_q.push_back(ds[i]);
    end
  endtask

  // Press enter and follow the enter pulse and the four issued digits.
  task automatic test_issue(input string tag);
    logic [3:0] e;
    n_cmp++;
    if (digit_cnt !== 3'd4) begin
      n_bad++; $display("FAIL %s cnt_before_enter: got %0d want 4", tag, digit_cnt);
    end
    press(4'hB);
    n_cmp++;
    if ({chk_enter, chk_digit, busy} !== {1'b1, 4'h0, 1'b1}) begin
      n_bad++; $display("FAIL %s enter_cycle: got %b want %b", tag,
                        {chk_enter, chk_digit, busy}, {1'b1, 4'h0, 1'b1});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (exp_q.size() == 0) begin
        e = 4'hx;
      end else begin
        e = exp_q.pop_front();
      end
      n_cmp++;
      if ({chk_enter, chk_digit} !== {1'b0, e}) begin
        n_bad++; $display("FAIL %s digit%0d: got %h want %h", tag, i, {chk_enter, chk_digit}, {1'b0, e});
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_valid = 1'b0; key_code = '0;
    chk_grant = 1'b0; chk_deny = 1'b0; chk_lock = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({chk_enter, chk_digit, busy, digit_cnt, entry_ok, entry_fail, entry_err, locked_out} !== 14'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %b want 0",
                        {chk_enter, chk_digit, busy, digit_cnt, entry_ok, entry_fail, entry_err, locked_out});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_grant();
    press_digits(4'd1, 4'd5, 4'd3, 4'd7);
    test_issue("grant");
    tick();
    n_cmp++;
    if ({chk_digit, busy, entry_ok} !== {4'h0, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL grant_wait: got %b want %b", {chk_digit, busy, entry_ok}, {4'h0, 1'b1, 1'b0});
    end
    chk_grant = 1'b1;
    tick();
    chk_grant = 1'b0;
    n_cmp++;
    if ({entry_ok, entry_fail, entry_err, digit_cnt, busy} !== {3'b100, 3'd0, 1'b0}) begin
      n_bad++; $display("FAIL grant_verdict: got %b want %b",
                        {entry_ok, entry_fail, entry_err, digit_cnt, busy}, {3'b100, 3'd0, 1'b0});
    end
    tick();
    n_cmp++;
    if (entry_ok !== 1'b0) begin
      n_bad++; $display("FAIL grant_pulse_width: got %b want 0", entry_ok);
    end
  endtask

  task automatic test_deny_unlocked();
    press_digits(4'd1, 4'd5, 4'd3, 4'd8);
    test_issue("deny");
    tick();
    chk_deny = 1'b1;
    tick();
    chk_deny = 1'b0;
    n_cmp++;
    if ({entry_ok, entry_fail, entry_err, busy, digit_cnt} !== {3'b010, 1'b1, 3'd0}) begin
      n_bad++; $display("FAIL deny_verdict: got %b want %b",
                        {entry_ok, entry_fail, entry_err, busy, digit_cnt}, {3'b010, 1'b1, 3'd0});
    end
    tick();
    n_cmp++;
    if ({entry_fail, busy, locked_out} !== 3'b000) begin
      n_bad++; $display("FAIL deny_return: got %b want 000", {entry_fail, busy, locked_out});
    end
  endtask

  task automatic test_deny_locked();
    int locked_cycles = 0;
    int pulses = 0;
    press_digits(4'd1, 4'd5, 4'd3, 4'd8);
    test_issue("lock");
    tick();
    chk_deny = 1'b1;
    tick();
    chk_deny = 1'b0;
    n_cmp++;
    if (entry_fail !== 1'b1) begin
      n_bad++; $display("FAIL lock_fail_pulse: got %b want 1", entry_fail);
    end
    chk_lock = 1'b1;
    for (int i = 0; i < 100; i++) begin
      key_valid = (i % 10 == 5);
      key_code  = (i % 20 == 5) ? 4'hB : 4'd2;
      tick();
      if (locked_out === 1'b1) locked_cycles++;
      if (entry_ok || entry_fail || entry_err || chk_enter) pulses++;
    end
    key_valid = 1'b0;
    key_code  = 4'h0;
    n_cmp++;
    if (locked_cycles !== 100) begin
      n_bad++; $display("FAIL locked_cycles: got %0d want 100", locked_cycles);
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++; $display("FAIL locked_pulses: got %0d want 0", pulses);
    end
    chk_lock = 1'b0;
    tick();
    n_cmp++;
    if ({locked_out, busy, digit_cnt} !== {1'b0, 1'b0, 3'd0}) begin
      n_bad++; $display("FAIL lock_release: got %b want 00000", {locked_out, busy, digit_cnt});
    end
  endtask

  task automatic test_short_enter();
    press(4'd1);
    press(4'd5);
    press(4'hB);
    n_cmp++;
    if ({entry_err, chk_enter, digit_cnt, busy} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
      n_bad++; $display("FAIL short_enter: got %b want %b",
                        {entry_err, chk_enter, digit_cnt, busy}, {1'b1, 1'b0, 3'd0, 1'b0});
    end
    tick();
    n_cmp++;
    if ({entry_err, chk_enter} !== 2'b00) begin
      n_bad++; $display("FAIL short_enter_after: got %b want 00", {entry_err, chk_enter});
    end
  endtask

  task automatic test_overflow();
    press_digits(4'd1, 4'd5, 4'd3, 4'd7);
    press(4'd9);
    n_cmp++;
    if ({entry_err, digit_cnt} !== {1'b1, 3'd4}) begin
      n_bad++; $display("FAIL overflow_key: got %b want %b", {entry_err, digit_cnt}, {1'b1, 3'd4});
    end
    test_issue("overflow");
    tick();
    chk_grant = 1'b1;
    tick();
    chk_grant = 1'b0;
    n_cmp++;
    if (entry_ok !== 1'b1) begin
      n_bad++; $display("FAIL overflow_grant: got %b want 1", entry_ok);
    end
    tick();
  endtask

  task automatic test_key_timeout();
    int early = 0;
    press(4'd4);
    n_cmp++;
    if (digit_cnt !== 3'd1) begin
      n_bad++; $display("FAIL timeout_first_key: got %0d want 1", digit_cnt);
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      if (entry_err || digit_cnt !== 3'd1) early++;
    end
    n_cmp++;
    if (early !== 0) begin
      n_bad++; $display("FAIL timeout_early: got %0d want 0", early);
    end
    tick();
    n_cmp++;
    if ({entry_err, digit_cnt} !== {1'b1, 3'd0}) begin
      n_bad++; $display("FAIL timeout_fire: got %b want %b", {entry_err, digit_cnt}, {1'b1, 3'd0});
    end
    tick();
  endtask

  task automatic test_clear();
    press(4'd1);
    press(4'd5);
    press(4'hA);
    n_cmp++;
    if ({digit_cnt, entry_ok, entry_fail, entry_err} !== 6'd0) begin
      n_bad++; $display("FAIL clear_key: got %b want 0", {digit_cnt, entry_ok, entry_fail, entry_err});
    end
  endtask

  task automatic test_result_timeout();
    int fire_at = -1;
    int others = 0;
    press_digits(4'd2, 4'd4, 4'd6, 4'd8);
    test_issue("rtimeout");
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (entry_err && fire_at < 0) fire_at = i;
      if (entry_ok || entry_fail) others++;
    end
    n_cmp++;
    if (fire_at !== 16) begin
      n_bad++; $display("FAIL result_timeout_cycle: got %0d want 16", fire_at);
    end
    n_cmp++;
    if ({others[3:0], busy, digit_cnt} !== {4'd0, 1'b0, 3'd0}) begin
      n_bad++; $display("FAIL result_timeout_state: got %b want 0", {others[3:0], busy, digit_cnt});
    end
  endtask

  task automatic test_reset_mid_issue();
    int noise = 0;
    press_digits(4'd9, 4'd8, 4'd7, 4'd6);
    press(4'hB);
    tick();
    tick();
    n_cmp++;
    if (chk_digit !== 4'd8) begin
      n_bad++; $display("FAIL midreset_d1: got %h want 8", chk_digit);
    end
    exp_q.delete();
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if ({chk_enter, chk_digit, busy, digit_cnt, entry_ok, entry_fail, entry_err, locked_out} !== 14'd0) begin
      n_bad++; $display("FAIL midreset_outputs: got %b want 0",
                        {chk_enter, chk_digit, busy, digit_cnt, entry_ok, entry_fail, entry_err, locked_out});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (chk_enter || chk_digit != 4'd0 || busy || entry_ok || entry_fail || entry_err) noise++;
    end
    n_cmp++;
    if (noise !== 0) begin
      n_bad++; $display("FAIL midreset_quiet: got %0d want 0", noise);
    end
  endtask

  task automatic test_grant_and_deny();
    press_digits(4'd3, 4'd3, 4'd0, 4'd1);
    test_issue("both");
    tick();
    chk_grant = 1'b1;
    chk_deny  = 1'b1;
    tick();
    chk_grant = 1'b0;
    chk_deny  = 1'b0;
    n_cmp++;
    if ({entry_ok, entry_fail, entry_err} !== 3'b010) begin
      n_bad++; $display("FAIL both_verdict: got %b want 010", {entry_ok, entry_fail, entry_err});
    end
    tick();
    n_cmp++;
    if ({busy, locked_out} !== 2'b00) begin
      n_bad++; $display("FAIL both_return: got %b want 00", {busy, locked_out});
    end
  endtask

  initial begin
    test_reset();
    test_grant();
    test_deny_unlocked();
    test_deny_locked();
    test_short_enter();
    test_overflow();
    test_key_timeout();
    test_clear();
    test_result_timeout();
    test_reset_mid_issue();
    test_grant_and_deny();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
